// File: rtl/latch_write_sequencer_pkg.sv
// latch_write_sequencer_pkg: shared state encodings, default timing constants and helpers
//   for the latch write sequencer and its phase counter.
package latch_write_sequencer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OPEN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_PULSE_CYC = 3;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/latch_write_sequencer_phase_counter.sv
// phase_counter: loadable down-counter with a zero flag, used to time each sequencer phase.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : load i_load_val this edge (takes priority over counting)
//   i_load_val   : value loaded on phase entry (phase length - 1)
//   o_zero       : counter has reached zero; the phase ends on the next edge
module phase_counter
    import latch_write_sequencer_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: drives D/E of a level-sensitive latch bank through setup, open and
//   hold phases for each accepted write, then checks the bank's Q against the written data.
//   clk, rst_n            : clock, asynchronous active-low reset (aborts any sequence)
//   i_req_valid/o_req_ready, i_req_data : write request handshake and data
//   o_e, o_d              : latch enable and data to the bank
//   i_q                   : bank read-back
//   o_busy                : sequence in progress
//   o_done, o_err         : one-cycle completion pulse and mismatch flag valid with it
module latch_write_sequencer
    import latch_write_sequencer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    input  logic [WIDTH-1:0] i_req_data,
    output logic             o_req_ready,
    output logic             o_e,
    output logic [WIDTH-1:0] o_d,
    input  logic [WIDTH-1:0] i_q,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);
    localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
        $error("latch_write_sequencer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end

    state_t         r_state;
    state_t         w_next;
    logic [WIDTH-1:0] r_d;
    logic           w_accept;
    logic           w_load;
    logic [CW-1:0]  w_load_val;
    logic           w_zero;
    logic           w_finish;

    // o_req_ready is a registered copy of (state == IDLE), so it is safe to qualify the accept.
    assign w_accept = i_req_valid & o_req_ready;
    assign w_finish = (r_state == ST_HOLD) & w_zero;
    assign o_d      = r_d;

    phase_counter #(.W(CW)) u_phase_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_next     = ST_SETUP;
                w_load     = 1'b1;
                w_load_val = CW'(SETUP_CYC - 1);
            end
            ST_SETUP: if (w_zero) begin
                w_next     = ST_OPEN;
                w_load     = 1'b1;
                w_load_val = CW'(PULSE_CYC - 1);
            end
            ST_OPEN: if (w_zero) begin
                w_next     = ST_HOLD;
                w_load     = 1'b1;
                w_load_val = CW'(HOLD_CYC - 1);
            end
            default: if (w_zero) w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so E moves only on phase edges while
    // D moves only on the accept edge, which is at least one setup cycle away from E rising.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_d         <= '0;
            o_req_ready <= 1'b1;
            o_e         <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            if (w_accept)
                r_d <= i_req_data;
            o_req_ready <= (w_next == ST_IDLE);
            o_e         <= (w_next == ST_OPEN);
            o_busy      <= (w_next != ST_IDLE);
            o_done      <= w_finish;
            o_err       <= w_finish & (i_q != r_d);
        end
    end
endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb_latch_write_sequencer: scoreboard bench driving the sequencer into a behavioural latch bank.
module tb_latch_write_sequencer;
    typedef struct {
        logic [7:0] data;
        logic [7:0] q;
        logic       err;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_req_valid = 1'b0;
    logic [7:0] i_req_data = 8'h00;
    logic       o_req_ready;
    logic       o_e;
    logic [7:0] o_d;
    logic [7:0] i_q;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    logic [7:0] bank_q = 8'h00;
    logic       force_zero = 1'b0;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   e_cnt = 0;
    logic prev_e = 1'b0;
    logic prev_done = 1'b0;

    latch_write_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_e         (o_e),
        .o_d         (o_d),
        .i_q         (i_q),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    always_latch if (o_e) bank_q <= o_d;
    assign i_q = force_zero ? 8'h00 : bank_q;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] qx;
        if (!rst_n) begin
            e_cnt = 0;
            prev_e = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (o_e) e_cnt++;
            if (o_e && !prev_e && sb.size() > 0) chk("e_rise_cycle", cyc, sb[0].acc + 2);
            if (o_busy && sb.size() > 0) chk("d_stable", o_d, sb[0].data);
            if (o_done) begin
                chk("done_single", prev_done, 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending write (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc, e.acc + 6);
                    chk("err", o_err, e.err);
                    chk("q_readback", i_q, e.q);
                    chk("e_pulse_len", e_cnt, 3);
                    done_cnt++;
                end
                e_cnt = 0;
            end else begin
                chk("err_idle", o_err, 0);
            end
            if (i_req_valid && o_req_ready) begin
                qx = force_zero ? 8'h00 : i_req_data;
                sb.push_back('{data: i_req_data, q: qx, err: (qx != i_req_data), acc: cyc + 1});
            end
            prev_e = o_e;
            prev_done = o_done;
        end
    end

    task automatic wr(input logic [7:0] v, input bit keep);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        i_req_valid = 1'b1;
        i_req_data = v;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 expected ready within 40 cycles");
        end
        @(posedge clk); #1;
        if (!keep) i_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_arrived", ok, 1);
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_e", o_e, 0);
        chk("rst_d", o_d, 8'h00);
        chk("rst_ready", o_req_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_e", o_e, 0);
            chk("idle_d", o_d, 8'h00);
            chk("idle_ready", o_req_ready, 1);
            chk("idle_busy", o_busy, 0);
            chk("idle_done", o_done, 0);
        end

        wr(8'hA5, 1'b0);
        wait_done(1);
        chk("q_a5", bank_q, 8'hA5);

        wr(8'h3C, 1'b1);
        wr(8'hC3, 1'b0);
        wait_done(3);
        chk("q_c3", bank_q, 8'hC3);

        wr(8'h5A, 1'b0);
        @(posedge clk); #1;
        i_req_valid = 1'b1;
        i_req_data = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_req_data = 8'h00;
        wait_done(4);
        chk("q_5a", bank_q, 8'h5A);
        repeat (3) @(negedge clk);
        chk("no_extra_accept", done_cnt, 4);

        force_zero = 1'b1;
        wr(8'h81, 1'b0);
        wait_done(5);
        @(posedge clk); #1;
        force_zero = 1'b0;

        wr(8'h77, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_e) begin
                seen = 1'b1;
                break;
            end
        end
        chk("open_reached", seen, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_e", o_e, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_ready", o_req_ready, 1);
        chk("abort_done", o_done, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, 5);

        wr(8'h96, 1'b0);
        wait_done(6);
        chk("q_96", bank_q, 8'h96);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("done_total", done_cnt, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
